// File: rtl/axis_frame_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_pkg
// Shared definitions for the AXI4-Stream frame generator:
//   state_t   : generator FSM state encoding (IDLE / SEND / GAP)
//   keep_mask : byte-lane remainder of the final beat -> tkeep pattern
// -----------------------------------------------------------------------------
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Widest tkeep the mask helper can produce; callers truncate to their width.
    localparam int MAX_KEEP_W = 64;

    // A remainder of 0 means the final beat is completely full.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned rem);
        if (rem == 0) begin
            keep_mask = '1;
        end else begin
            keep_mask = (64'd1 << rem) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// -----------------------------------------------------------------------------
// axis_frame_gen
// AXI4-Stream test-frame source. Frames carry byte k of frame f equal to
// (seed + f + k) mod 256, so a downstream checker can verify them without
// any side channel. All outputs are registered; tready only gates updates.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cfg_len/count/seed/gap/id/dest : run configuration, sampled on accepted start
//   start, stop         : single-cycle run control requests
//   busy                : a run is in progress
//   frames_sent         : completed frames since reset (wraps)
//   m_axis_*            : AXI4-Stream master
// -----------------------------------------------------------------------------
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [15:0]           cfg_count,
    input  logic [7:0]            cfg_seed,
    input  logic [7:0]            cfg_gap,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic [31:0]           frames_sent,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic                  m_axis_tuser
);

    state_t                r_state, w_state_next;
    logic [LEN_WIDTH-1:0]  r_len, r_k0, w_k0_next, w_len_use;
    logic [15:0]           r_count, r_fidx, w_fidx_next;
    logic [7:0]            r_seed, r_gap, r_gap_cnt, w_gap_cnt_next, w_seed_use;
    logic                  r_stop_pend, w_stop_pend_next;
    logic                  r_busy, w_busy_next;
    logic                  r_tvalid, w_tvalid_next;
    logic                  r_tlast, w_tlast;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep, w_tkeep;
    logic [ID_WIDTH-1:0]   r_tid;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [31:0]           r_frames_sent;
    logic                  w_start_ok, w_hs, w_stop_now, w_run_done;
    logic                  w_frame_done, w_load_beat;

    assign w_start_ok   = (r_state == ST_IDLE) && start && (cfg_len != '0);
    assign w_hs         = r_tvalid && m_axis_tready;
    // A stop arriving on the same cycle as the final handshake still counts.
    assign w_stop_now   = r_stop_pend || stop;
    assign w_run_done   = ((r_count != 16'd0) && ((r_fidx + 16'd1) == r_count)) || w_stop_now;
    assign w_frame_done = (r_state == ST_SEND) && w_hs && r_tlast;

    // On the start cycle the configuration registers are not loaded yet.
    assign w_seed_use = (r_state == ST_IDLE) ? cfg_seed : r_seed;
    assign w_len_use  = (r_state == ST_IDLE) ? cfg_len  : r_len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_frame_done) begin
                    if (w_run_done)        w_state_next = ST_IDLE;
                    else if (r_gap != '0)  w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_stop_now)                w_state_next = ST_IDLE;
                else if (r_gap_cnt <= 8'd1)    w_state_next = ST_SEND;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output / datapath control: decides what the registered outputs become.
    always_comb begin
        w_load_beat      = 1'b0;
        w_fidx_next      = r_fidx;
        w_k0_next        = r_k0;
        w_tvalid_next    = r_tvalid;
        w_busy_next      = r_busy;
        w_gap_cnt_next   = r_gap_cnt;
        w_stop_pend_next = r_stop_pend || (stop && r_busy);
        unique case (r_state)
            ST_IDLE: begin
                w_stop_pend_next = 1'b0;
                if (w_start_ok) begin
                    w_load_beat   = 1'b1;
                    w_fidx_next   = '0;
                    w_k0_next     = '0;
                    w_tvalid_next = 1'b1;
                    w_busy_next   = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        if (w_run_done) begin
                            w_tvalid_next    = 1'b0;
                            w_busy_next      = 1'b0;
                            w_stop_pend_next = 1'b0;
                        end else if (r_gap == '0) begin
                            // Back-to-back frames: next first beat without a bubble.
                            w_load_beat = 1'b1;
                            w_fidx_next = r_fidx + 16'd1;
                            w_k0_next   = '0;
                        end else begin
                            w_tvalid_next  = 1'b0;
                            w_gap_cnt_next = r_gap;
                        end
                    end else begin
                        w_load_beat = 1'b1;
                        w_k0_next   = r_k0 + LEN_WIDTH'(KEEP_WIDTH);
                    end
                end
            end
            ST_GAP: begin
                if (w_stop_now) begin
                    w_busy_next      = 1'b0;
                    w_stop_pend_next = 1'b0;
                end else if (r_gap_cnt <= 8'd1) begin
                    w_load_beat   = 1'b1;
                    w_fidx_next   = r_fidx + 16'd1;
                    w_k0_next     = '0;
                    w_tvalid_next = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Beat contents for the frame index / byte offset being loaded.
    always_comb begin
        logic [LEN_WIDTH:0] k;
        logic [LEN_WIDTH:0] k_end;
        k       = '0;
        w_tdata = '0;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            k = {1'b0, w_k0_next} + (LEN_WIDTH+1)'(j);
            // Lanes past the frame end stay zero.
            if (k < {1'b0, w_len_use}) begin
                w_tdata[j*8 +: 8] = w_seed_use + w_fidx_next[7:0] + k[7:0];
            end
        end
        k_end   = {1'b0, w_k0_next} + (LEN_WIDTH+1)'(KEEP_WIDTH);
        w_tlast = (k_end >= {1'b0, w_len_use});
        w_tkeep = w_tlast ? KEEP_WIDTH'(keep_mask(32'(w_len_use % LEN_WIDTH'(KEEP_WIDTH))))
                          : '1;
    end

    // Registered outputs and run control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid      <= 1'b0;
            r_busy        <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_gap_cnt     <= '0;
            r_frames_sent <= '0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tlast       <= 1'b0;
            r_tid         <= '0;
            r_tdest       <= '0;
        end else begin
            r_tvalid    <= w_tvalid_next;
            r_busy      <= w_busy_next;
            r_stop_pend <= w_stop_pend_next;
            r_gap_cnt   <= w_gap_cnt_next;
            if (w_frame_done) r_frames_sent <= r_frames_sent + 32'd1;
            if (w_load_beat) begin
                r_tdata <= w_tdata;
                r_tkeep <= w_tkeep;
                r_tlast <= w_tlast;
            end
            if (w_start_ok) begin
                r_tid   <= cfg_id;
                r_tdest <= cfg_dest;
            end
        end
    end

    // Run configuration and position counters; meaningful only while busy.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_len   <= cfg_len;
            r_count <= cfg_count;
            r_seed  <= cfg_seed;
            r_gap   <= cfg_gap;
        end
        if (w_load_beat) begin
            r_fidx <= w_fidx_next;
            r_k0   <= w_k0_next;
        end
    end

    assign busy          = r_busy;
    assign frames_sent   = r_frames_sent;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = KEEP_ENABLE ? r_tkeep : '1;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign m_axis_tdest  = r_tdest;
    assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_axis_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_gen
// Drives an 8-bit and a 32-bit generator with the same configuration and
// checks each stream beat-by-beat against a byte-level model of the payload
// rule, plus hold-under-backpressure, inter-frame gap and run-end behaviour.
// -----------------------------------------------------------------------------
module tb_axis_frame_gen;

    logic        clk, rst, start, stop;
    logic [15:0] cfg_len, cfg_count;
    logic [7:0]  cfg_seed, cfg_gap, cfg_id, cfg_dest;

    logic        d8_busy, d8_tvalid, d8_tlast, d8_tuser;
    logic [31:0] d8_sent;
    logic [7:0]  d8_tdata, d8_tid, d8_tdest;
    logic [0:0]  d8_tkeep;
    logic        d32_busy, d32_tvalid, d32_tlast, d32_tuser;
    logic [31:0] d32_sent, d32_tdata;
    logic [7:0]  d32_tid, d32_tdest;
    logic [3:0]  d32_tkeep;

    logic        rdy [2];
    logic [31:0] mw_data [2];
    logic [3:0]  mw_keep [2];
    logic        mw_valid [2], mw_last [2], mw_busy [2], mw_user [2];
    logic [7:0]  mw_id [2], mw_dest [2];
    logic [31:0] mw_sent [2];

    int n_checks = 0;
    int n_errors = 0;
    int run_id = 0;
    int rdy_pct = 100;
    bit stop_flag = 0;
    int exp_len, exp_count, exp_seed, exp_gap, exp_id, exp_dest;
    logic [31:0] sent_base [2];

    axis_frame_gen #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .cfg_seed(cfg_seed), .cfg_gap(cfg_gap), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .start(start), .stop(stop), .busy(d8_busy), .frames_sent(d8_sent),
        .m_axis_tdata(d8_tdata), .m_axis_tkeep(d8_tkeep), .m_axis_tvalid(d8_tvalid),
        .m_axis_tready(rdy[0]), .m_axis_tlast(d8_tlast), .m_axis_tid(d8_tid),
        .m_axis_tdest(d8_tdest), .m_axis_tuser(d8_tuser)
    );

    axis_frame_gen #(.DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .cfg_seed(cfg_seed), .cfg_gap(cfg_gap), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .start(start), .stop(stop), .busy(d32_busy), .frames_sent(d32_sent),
        .m_axis_tdata(d32_tdata), .m_axis_tkeep(d32_tkeep), .m_axis_tvalid(d32_tvalid),
        .m_axis_tready(rdy[1]), .m_axis_tlast(d32_tlast), .m_axis_tid(d32_tid),
        .m_axis_tdest(d32_tdest), .m_axis_tuser(d32_tuser)
    );

    assign mw_data[0]  = {24'd0, d8_tdata};
    assign mw_data[1]  = d32_tdata;
    assign mw_keep[0]  = {3'd0, d8_tkeep};
    assign mw_keep[1]  = d32_tkeep;
    assign mw_valid[0] = d8_tvalid;
    assign mw_valid[1] = d32_tvalid;
    assign mw_last[0]  = d8_tlast;
    assign mw_last[1]  = d32_tlast;
    assign mw_busy[0]  = d8_busy;
    assign mw_busy[1]  = d32_busy;
    assign mw_user[0]  = d8_tuser;
    assign mw_user[1]  = d32_tuser;
    assign mw_id[0]    = d8_tid;
    assign mw_id[1]    = d32_tid;
    assign mw_dest[0]  = d8_tdest;
    assign mw_dest[1]  = d32_tdest;
    assign mw_sent[0]  = d8_sent;
    assign mw_sent[1]  = d32_sent;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy[0] = ($urandom_range(99) < rdy_pct);
            rdy[1] = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor + payload model, one per DUT width.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int KW = (g == 0) ? 1 : 4;
        int f = 0, nbytes = 0, idle_cnt = 0, beats_run = 0, seen_run = 0, last_gap = -1;
        bit gap_pend = 0, end_chk = 0, prev_stall = 0;
        logic [31:0] prev_data;
        logic [3:0]  prev_keep;
        logic        prev_last;
        logic [31:0] bd [8];
        logic [3:0]  bk [8];
        logic        bl [8];

        initial begin : mon
            string pfx;
            int rem;
            logic [31:0] ed;
            logic [3:0]  ek;
            pfx = (g == 0) ? "w8" : "w32";
            forever begin
                @(negedge clk);
                if (seen_run != run_id) begin
                    seen_run = run_id; f = 0; nbytes = 0; beats_run = 0;
                    gap_pend = 0; end_chk = 0; last_gap = -1;
                end
                if (rst) begin
                    prev_stall = 0; gap_pend = 0; end_chk = 0;
                end else begin
                    if (end_chk) begin
                        check_eq({pfx, "_end_busy_valid"}, {mw_busy[g], mw_valid[g]}, 2'b00);
                        end_chk = 0;
                    end
                    if (prev_stall) begin
                        check_eq({pfx, "_hold_valid"}, mw_valid[g], 1'b1);
                        check_eq({pfx, "_hold_data"}, mw_data[g], prev_data);
                        check_eq({pfx, "_hold_keep"}, mw_keep[g], prev_keep);
                        check_eq({pfx, "_hold_last"}, mw_last[g], prev_last);
                    end
                    prev_stall = 0;
                    if (mw_valid[g]) begin
                        if (gap_pend) begin
                            check_eq({pfx, "_gap_len"}, idle_cnt, exp_gap);
                            last_gap = idle_cnt;
                            gap_pend = 0;
                        end
                        if (rdy[g]) begin
                            rem = exp_len - nbytes;
                            ed = '0;
                            for (int j = 0; j < KW; j++)
                                if (j < rem) ed[j*8 +: 8] = 8'(exp_seed + f + nbytes + j);
                            ek = (rem >= KW) ? 4'((1 << KW) - 1) : 4'((1 << rem) - 1);
                            check_eq({pfx, "_data"}, mw_data[g], ed);
                            check_eq({pfx, "_keep"}, mw_keep[g], ek);
                            check_eq({pfx, "_last"}, mw_last[g], rem <= KW);
                            check_eq({pfx, "_id_dest_user"}, {mw_id[g], mw_dest[g], mw_user[g]},
                                     {8'(exp_id), 8'(exp_dest), 1'b0});
                            if (beats_run < 8) begin
                                bd[beats_run] = mw_data[g];
                                bk[beats_run] = mw_keep[g];
                                bl[beats_run] = mw_last[g];
                            end
                            beats_run++;
                            if (rem <= KW) begin
                                f++;
                                nbytes = 0;
                                if ((exp_count != 0 && f == exp_count) || stop_flag) begin
                                    end_chk = 1;
                                end else begin
                                    gap_pend = 1;
                                    idle_cnt = 0;
                                end
                            end else begin
                                nbytes += KW;
                            end
                        end else begin
                            prev_stall = 1;
                            prev_data = mw_data[g];
                            prev_keep = mw_keep[g];
                            prev_last = mw_last[g];
                        end
                    end else if (gap_pend) begin
                        idle_cnt++;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_begin(input int len, input int count, input int seed, input int gap,
                             input int pct);
        exp_len = len; exp_count = count; exp_seed = seed; exp_gap = gap;
        exp_id = $urandom_range(255); exp_dest = $urandom_range(255);
        cfg_len = 16'(len); cfg_count = 16'(count); cfg_seed = 8'(seed); cfg_gap = 8'(gap);
        cfg_id = 8'(exp_id); cfg_dest = 8'(exp_dest);
        rdy_pct = pct;
        stop_flag = 0;
        sent_base[0] = d8_sent;
        sent_base[1] = d32_sent;
        run_id++;
        pulse_start();
    endtask

    task automatic run_end(input int exp8, input int exp32);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((d8_busy || d32_busy) && cyc < 4000);
        check_eq("run_timeout", cyc >= 4000, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("w8_frames_sent", d8_sent - sent_base[0], 32'(g_mon[0].f));
        check_eq("w32_frames_sent", d32_sent - sent_base[1], 32'(g_mon[1].f));
        if (exp8 >= 0)  check_eq("w8_frames", g_mon[0].f, exp8);
        if (exp32 >= 0) check_eq("w32_frames", g_mon[1].f, exp32);
    endtask

    task automatic wait_mon0(input int fi, input int nb, input string tag);
        int cyc;
        cyc = 0;
        while (!(g_mon[0].f == fi && g_mon[0].nbytes >= nb) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check_eq(tag, cyc >= 2000, 1'b0);
    endtask

    initial begin : main
        logic [7:0] t1 [8];
        int cyc, any;
        t1 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h11, 8'h12, 8'h13, 8'h14};
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_len = '0; cfg_count = '0; cfg_seed = '0; cfg_gap = '0; cfg_id = '0; cfg_dest = '0;
        exp_len = 0; exp_count = 0; exp_seed = 0; exp_gap = 0; exp_id = 0; exp_dest = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_w32_outs", {d32_tvalid, d32_busy, d32_tlast, d32_tdata, d32_tkeep, d32_tid, d32_tdest},
                 '0);
        check_eq("reset_w8_outs", {d8_tvalid, d8_busy, d8_tlast, d8_tdata, d8_tkeep, d8_tid, d8_tdest},
                 {3'b000, 8'h00, 1'b1, 16'h0000});
        check_eq("reset_sent", {d8_sent, d32_sent}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Two 4-byte frames, full throughput
        run_begin(4, 2, 8'h10, 0, 100);
        run_end(2, 2);
        for (int i = 0; i < 8; i++) begin
            check_eq("t1_w8_beat", {g_mon[0].bd[i][7:0], g_mon[0].bl[i]}, {t1[i], (i % 4) == 3});
        end
        check_eq("t1_w32_beat0", {g_mon[1].bd[0], g_mon[1].bk[0], g_mon[1].bl[0]}, {32'h13121110, 4'hF, 1'b1});
        check_eq("t1_w32_beat1", {g_mon[1].bd[1], g_mon[1].bk[1], g_mon[1].bl[1]}, {32'h14131211, 4'hF, 1'b1});
        check_eq("t1_no_bubble", g_mon[0].last_gap, 0);

        // Partial last beat on the wide stream
        run_begin(6, 1, 0, 0, 100);
        run_end(1, 1);
        check_eq("t2_w32_beat0", {g_mon[1].bd[0], g_mon[1].bk[0], g_mon[1].bl[0]}, {32'h03020100, 4'hF, 1'b0});
        check_eq("t2_w32_beat1", {g_mon[1].bd[1], g_mon[1].bk[1], g_mon[1].bl[1]}, {32'h00000504, 4'h3, 1'b1});
        check_eq("t2_w8_beat5", {g_mon[0].bd[5][7:0], g_mon[0].bl[5]}, {8'h05, 1'b1});

        // Same as the first run, with random backpressure
        run_begin(4, 2, 8'h10, 0, 50);
        run_end(2, 2);
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_w8_beat", {g_mon[0].bd[i][7:0], g_mon[0].bl[i]}, {t1[i], (i % 4) == 3});
        end

        // Inter-frame gap of 3; a start pulsed while the wide DUT sits in GAP
        run_begin(9, 2, 8'h33, 3, 100);
        cyc = 0;
        while (!(g_mon[1].gap_pend && g_mon[1].idle_cnt >= 1) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check_eq("t4_trigger_timeout", cyc >= 200, 1'b0);
        cfg_len = 16'd3; cfg_seed = 8'hAA; cfg_count = 16'd5;
        pulse_start();
        run_end(2, 2);
        check_eq("t4_w8_gap", g_mon[0].last_gap, 3);
        check_eq("t4_w32_gap", g_mon[1].last_gap, 3);

        // Continuous mode, stop on beat 3 of frame 2; stray start earlier
        run_begin(8, 0, 8'h40, 0, 100);
        wait_mon0(1, 2, "t5_trig1_timeout");
        cfg_len = 16'd3; cfg_seed = 8'hAA;
        pulse_start();
        wait_mon0(2, 3, "t5_trig2_timeout");
        #1 stop = 1'b1; stop_flag = 1;
        @(posedge clk); #1 stop = 1'b0;
        run_end(3, -1);

        // Reset in the middle of a frame, then a zero-length start
        run_begin(8, 0, 8'h21, 0, 100);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_valid_busy", {d8_tvalid, d8_busy, d32_tvalid, d32_busy}, 4'b0000);
        check_eq("t6_rst_sent", {d8_sent, d32_sent}, 64'd0);
        exp_len = 0;
        run_id++;
        cfg_len = 16'd0; cfg_count = 16'd1;
        pulse_start();
        any = 0;
        repeat (10) begin
            @(negedge clk);
            if (d8_busy || d32_busy || d8_tvalid || d32_tvalid) any++;
        end
        check_eq("t6_len0_ignored", any, 0);
        check_eq("t6_len0_beats", g_mon[0].beats_run + g_mon[1].beats_run, 0);

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            int len, cnt;
            len = $urandom_range(1, 20);
            cnt = $urandom_range(1, 3);
            run_begin(len, cnt, $urandom_range(255), $urandom_range(0, 3), $urandom_range(30, 100));
            run_end(cnt, cnt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
